toggle_ack_responder: RTL

Receiving end of the two-phase toggle flag/ack handshake used for clock-domain flag crossings.
- Synchronises an asynchronous request toggle from a remote domain into CLK.
- Emits a one-cycle FLAG_OUT pulse and captures the bundled payload.
- Holds off until the local consumer signals DONE, then flips ACK_TOGGLE back to the remote domain.
- Sits at the destination-domain side of command and trigger paths between the USB/readout logic and the front-end logic.

---
 rtl/toggle_ack_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/toggle_ack_responder.sv
// Destination side of a two-phase toggle flag/ack crossing: synchronise the request toggle,
// pulse FLAG_OUT, hold BUSY until DONE, then flip ACK_TOGGLE. Optional: TOGGLE_ACK_TIMEOUT_EN.
module toggle_ack_responder #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  REQ_TOGGLE_ASYNC,
   input  logic [DATA_WIDTH-1:0] REQ_DATA_ASYNC,
   output logic                  ACK_TOGGLE,
   output logic                  FLAG_OUT,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   input  logic                  DONE,
   output logic                  BUSY,
   output logic [15:0]           REQ_COUNT,
   output logic                  OVERRUN,
   output logic                  TIMEOUT
);

   typedef enum logic [1:0] {StIdle, StFlag, StWaitDone} state_e;

   state_e                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    prev_q;
   logic                    req_edge;
   logic                    ack_q, ack_d;
   logic [15:0]             count_q, count_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    overrun_q, overrun_d;
   logic                    busy;
   logic                    timeout_hit;

   assign req_edge = sync_q[SYNC_STAGES-1] ^ prev_q;
   assign busy     = (state_q != StIdle);

`ifdef TOGGLE_ACK_TIMEOUT_EN
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        timeout_q;

   assign timeout_hit = busy && !DONE && (wait_cnt_q == 16'(TIMEOUT_CYCLES));

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q == StIdle && req_edge) begin
         wait_cnt_d = '0;
      end else if (busy && !DONE) begin
         wait_cnt_d = wait_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         if (timeout_hit) timeout_q <= 1'b1;
      end
   end

   assign TIMEOUT = timeout_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
   assign timeout_hit        = 1'b0;
   assign TIMEOUT            = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      ack_d     = ack_q;
      count_d   = count_q;
      data_d    = data_q;
      overrun_d = overrun_q;
      unique case (state_q)
         StIdle: begin
            if (req_edge) begin
               state_d = StFlag;
               data_d  = REQ_DATA_ASYNC;
            end
         end
         StFlag, StWaitDone: begin
            // A new toggle before our ack is a protocol violation; it is dropped, not queued.
            if (req_edge) overrun_d = 1'b1;
            if (DONE || timeout_hit) begin
               state_d = StIdle;
               ack_d   = ~ack_q;
               count_d = count_q + 16'd1;
            end else begin
               state_d = StWaitDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q   <= StIdle;
         sync_q    <= '0;
         prev_q    <= 1'b0;
         ack_q     <= 1'b0;
         count_q   <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], REQ_TOGGLE_ASYNC};
         prev_q    <= sync_q[SYNC_STAGES-1];
         ack_q     <= ack_d;
         count_q   <= count_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   assign ACK_TOGGLE = ack_q;
   assign FLAG_OUT   = (state_q == StFlag);
   assign BUSY       = busy;
   assign DATA_OUT   = data_q;
   assign REQ_COUNT  = count_q;
   assign OVERRUN    = overrun_q;

endmodule
